chao_seq_ctrl: RTL and testbench

- Sequencer for the four-output chaotic sequence generator.
- Per command, it runs the generator for N iterations using the generator's ap_start/ap_ready handshake.
- Each iteration's x/y/z/w results may arrive on different cycles, each with its own ap_valid; the block collects all four.
- It then emits them as four 32-bit AXI-Stream beats (x, y, z, w), with TLAST on the final beat of the command, plus a watchdog on the generator.

---
 rtl/chao_seq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_chao_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chao_seq_ctrl.sv
// Sequencer for the four-output chaotic generator: runs N start/collect
// iterations per command and streams each iteration's x/y/z/w as AXI-Stream beats.
// Ports: command (cmd_start/cmd_len, busy/done/err_timeout), generator
// handshake + per-result valids, AXI-Stream master (tdata/tvalid/tready/tlast).
// Latency: 1 START + 1 COLLECT + 4 EMIT cycles minimum per iteration; all outputs registered.
// Backpressure: beats hold stable while m_axis_tready is low; watchdog aborts a stuck COLLECT.
module chao_seq_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              gen_ap_start,
    input  logic              gen_ap_ready,
    input  logic [DATA_W-1:0] gen_x,
    input  logic [DATA_W-1:0] gen_y,
    input  logic [DATA_W-1:0] gen_z,
    input  logic [DATA_W-1:0] gen_w,
    input  logic              gen_x_vld,
    input  logic              gen_y_vld,
    input  logic              gen_z_vld,
    input  logic              gen_w_vld,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    // Watchdog fires on the TIMEOUT-th COLLECT cycle (counter starts at 0).
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    logic [2:0]              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    ap_start_q, ap_start_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [DATA_W-1:0]       tdata_q, tdata_d;
    logic [3:0]              flags_q, flags_d;
    logic [3:0][DATA_W-1:0]  hold_q, hold_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [7:0]              wd_q, wd_d;
    logic [1:0]              beat_q, beat_d;

    // Channel index 0..3 = x, y, z, w (also the beat order).
    logic [3:0]              vld_in;
    logic [3:0][DATA_W-1:0]  dat_in;
    logic [1:0]              beat_nxt;

    assign vld_in   = {gen_w_vld, gen_z_vld, gen_y_vld, gen_x_vld};
    assign dat_in   = {gen_w, gen_z, gen_y, gen_x};
    assign beat_nxt = beat_q + 2'd1;

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ap_start_d = ap_start_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        flags_d    = flags_q;
        hold_d     = hold_q;
        rem_d      = rem_q;
        wd_d       = wd_q;
        beat_d     = beat_q;

        // Captures open already in START so results that arrive together
        // with ap_ready are not lost. First valid per channel wins.
        if (state_q == S_START || state_q == S_COLLECT) begin
            for (int i = 0; i < 4; i++) begin
                if (vld_in[i] && !flags_q[i]) begin
                    flags_d[i] = 1'b1;
                    hold_d[i]  = dat_in[i];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    err_d = 1'b0;
                    if (cmd_len != '0) begin
                        rem_d      = cmd_len;
                        busy_d     = 1'b1;
                        ap_start_d = 1'b1;
                        flags_d    = '0;
                        wd_d       = '0;
                        state_d    = S_START;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end
            S_START: begin
                if (gen_ap_ready) begin
                    ap_start_d = 1'b0;
                    wd_d       = '0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (&flags_d) begin
                    // Present beat 0 from the freshly merged holding registers.
                    state_d  = S_EMIT;
                    beat_d   = 2'd0;
                    tvalid_d = 1'b1;
                    tdata_d  = hold_d[0];
                    tlast_d  = 1'b0;
                    wd_d     = '0;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    flags_d = '0;
                    wd_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_EMIT: begin
                if (tvalid_q && m_axis_tready) begin
                    if (beat_q == 2'd3) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        flags_d  = '0;
                        rem_d    = rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_FINISH;
                        end else begin
                            ap_start_d = 1'b1;
                            state_d    = S_START;
                        end
                    end else begin
                        beat_d  = beat_nxt;
                        tdata_d = hold_q[beat_nxt];
                        tlast_d = (beat_nxt == 2'd3) && (rem_q == LEN_W'(1));
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ap_start_q <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            flags_q    <= '0;
            hold_q     <= '0;
            rem_q      <= '0;
            wd_q       <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ap_start_q <= ap_start_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            flags_q    <= flags_d;
            hold_q     <= hold_d;
            rem_q      <= rem_d;
            wd_q       <= wd_d;
            beat_q     <= beat_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_timeout   = err_q;
    assign gen_ap_start  = ap_start_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_chao_seq_ctrl.sv
// Bench for chao_seq_ctrl: behavioural generator pushes expected beats into a
// scoreboard queue; a negedge monitor pops and compares on each handshake.
module tb_chao_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic [15:0] cmd_len;
    logic        busy, done, err_timeout;
    logic        gen_ap_start, gen_ap_ready;
    logic [31:0] gen_x, gen_y, gen_z, gen_w;
    logic        gen_x_vld, gen_y_vld, gen_z_vld, gen_w_vld;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

    always #5 clk = ~clk;

    chao_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_len(cmd_len),
        .busy(busy), .done(done), .err_timeout(err_timeout),
        .gen_ap_start(gen_ap_start), .gen_ap_ready(gen_ap_ready),
        .gen_x(gen_x), .gen_y(gen_y), .gen_z(gen_z), .gen_w(gen_w),
        .gen_x_vld(gen_x_vld), .gen_y_vld(gen_y_vld),
        .gen_z_vld(gen_z_vld), .gen_w_vld(gen_w_vld),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed { logic [31:0] d; logic l; } beat_t;
    beat_t sb_q[$];

    // Generator model controls
    int mode      = 0;   // 0: all valids with ap_ready, 1: staggered + duplicate x, 2: z never valid
    int ready_dly = 2;
    int cur_len   = 1;
    int iter      = 0;

    // Monitor state
    int          beats = 0, lasts = 0, acc_cnt = 0, done_cnt = 0;
    int          neg_idx = 0, acc_idx = 0, err_idx = 0;
    logic        prev_stall = 1'b0, prev_last = 1'b0, prev_err = 1'b0;
    logic [31:0] prev_data = '0;

    int          tr_toggle = 0;
    int          tr_ph = 0;
    logic [3:0]  tr_pat = 4'b1001;

    function automatic logic [31:0] gdat(input int ch, input int it);
        return 32'(32'h11 * (ch + 1) + (it << 8));
    endfunction

    task automatic push_iter();
        for (int ch = 0; ch < 4; ch++) begin
            beat_t b;
            b.d = gdat(ch, iter);
            b.l = (ch == 3) && (iter == cur_len - 1);
            sb_q.push_back(b);
        end
        iter++;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Behavioural generator
    initial begin : gen_model
        gen_ap_ready = 0;
        {gen_x_vld, gen_y_vld, gen_z_vld, gen_w_vld} = 4'b0;
        gen_x = '0; gen_y = '0; gen_z = '0; gen_w = '0;
        forever begin
            @(negedge clk);
            if (gen_ap_start) begin
                repeat (ready_dly) @(negedge clk);
                step();
                gen_ap_ready = 1;
                if (mode == 0) begin
                    gen_x = gdat(0, iter); gen_y = gdat(1, iter);
                    gen_z = gdat(2, iter); gen_w = gdat(3, iter);
                    {gen_x_vld, gen_y_vld, gen_z_vld, gen_w_vld} = 4'b1111;
                    push_iter();
                end
                step();
                gen_ap_ready = 0;
                {gen_x_vld, gen_y_vld, gen_z_vld, gen_w_vld} = 4'b0;
                if (mode == 1) begin
                    gen_w = gdat(3, iter); gen_w_vld = 1; step();
                    gen_w_vld = 0; gen_x = gdat(0, iter); gen_x_vld = 1; step();
                    gen_x = 32'h99; step();
                    gen_x_vld = 0; gen_z = gdat(2, iter); gen_z_vld = 1; step();
                    gen_z_vld = 0; gen_y = gdat(1, iter); gen_y_vld = 1;
                    push_iter(); step();
                    gen_y_vld = 0;
                end else if (mode == 2) begin
                    gen_x = gdat(0, iter); gen_y = gdat(1, iter); gen_w = gdat(3, iter);
                    {gen_x_vld, gen_y_vld, gen_w_vld} = 3'b111; step();
                    {gen_x_vld, gen_y_vld, gen_w_vld} = 3'b000;
                end
            end
        end
    end

    // tready pattern 1,0,0,1,... when enabled
    always @(posedge clk) begin
        #1;
        if (tr_toggle != 0) begin
            m_axis_tready = tr_pat[tr_ph % 4];
            tr_ph++;
        end
    end

    // Output monitor / scoreboard
    always @(negedge clk) begin
        neg_idx++;
        if (done) done_cnt++;
        if (gen_ap_start && gen_ap_ready) begin
            acc_cnt++;
            acc_idx = neg_idx;
        end
        if (err_timeout && !prev_err) err_idx = neg_idx;
        prev_err = err_timeout;
        if (m_axis_tvalid && prev_stall) begin
            check_eq("stall_tdata", m_axis_tdata, prev_data);
            check_eq("stall_tlast", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            if (m_axis_tlast) lasts++;
            check_eq("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                beat_t b;
                b = sb_q.pop_front();
                check_eq("beat_tdata", m_axis_tdata, b.d);
                check_eq("beat_tlast", m_axis_tlast, b.l);
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    end

    task automatic send_cmd(input int len, input bit upd_model);
        step();
        if (upd_model) begin
            cur_len = len;
            iter    = 0;
        end
        cmd_start = 1;
        cmd_len   = 16'(len);
        step();
        cmd_start = 0;
        cmd_len   = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, done_cnt > d0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"},   busy, 0);
        check_eq({tag, "_done"},   done, 0);
        check_eq({tag, "_err"},    err_timeout, 0);
        check_eq({tag, "_start"},  gen_ap_start, 0);
        check_eq({tag, "_tvalid"}, m_axis_tvalid, 0);
        check_eq({tag, "_tlast"},  m_axis_tlast, 0);
        check_eq({tag, "_tdata"},  m_axis_tdata, 0);
    endtask

    task automatic run_basic(input string tag);
        int b0, l0, a0, d0;
        b0 = beats; l0 = lasts; a0 = acc_cnt; d0 = done_cnt;
        mode = 0;
        send_cmd(1, 1);
        check_eq({tag, "_busy_after_cmd"}, busy, 1);
        wait_done({tag, "_done_seen"}, 200);
        repeat (3) step();
        check_eq({tag, "_beats"}, beats - b0, 4);
        check_eq({tag, "_lasts"}, lasts - l0, 1);
        check_eq({tag, "_acc"},   acc_cnt - a0, 1);
        check_eq({tag, "_dones"}, done_cnt - d0, 1);
        check_eq({tag, "_busy_end"}, busy, 0);
        check_eq({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin : main
        int b0, l0, a0, d0, n;
        rst_n = 0;
        cmd_start = 0;
        cmd_len = '0;
        m_axis_tready = 1;
        #12;
        check_idle_outputs("reset");
        step();
        rst_n = 1;
        step();

        // Basic single iteration
        run_basic("basic");

        // Staggered arrival with duplicate x
        b0 = beats; d0 = done_cnt;
        mode = 1;
        send_cmd(1, 1);
        wait_done("stagger_done", 200);
        repeat (2) step();
        check_eq("stagger_beats", beats - b0, 4);
        check_eq("stagger_dones", done_cnt - d0, 1);

        // Three iterations with tready backpressure; a start mid-run is ignored
        b0 = beats; l0 = lasts; a0 = acc_cnt; d0 = done_cnt;
        mode = 0;
        tr_ph = 0;
        tr_toggle = 1;
        send_cmd(3, 1);
        repeat (4) step();
        check_eq("multi_busy_mid", busy, 1);
        send_cmd(5, 0);
        wait_done("multi_done", 400);
        tr_toggle = 0;
        step();
        m_axis_tready = 1;
        repeat (10) step();
        check_eq("multi_beats", beats - b0, 12);
        check_eq("multi_lasts", lasts - l0, 1);
        check_eq("multi_acc",   acc_cnt - a0, 3);
        check_eq("multi_dones", done_cnt - d0, 1);
        check_eq("multi_busy_end", busy, 0);
        check_eq("multi_sb_empty", sb_q.size(), 0);

        // Watchdog timeout: z never arrives
        b0 = beats; d0 = done_cnt; a0 = acc_cnt;
        mode = 2;
        send_cmd(2, 1);
        n = 0;
        while (!err_timeout && n < 400) begin
            step();
            n++;
        end
        check_eq("to_err_set", err_timeout, 1);
        check_eq("to_busy", busy, 0);
        repeat (5) step();
        check_eq("to_delay", err_idx - acc_idx, 256);
        check_eq("to_acc", acc_cnt - a0, 1);
        check_eq("to_no_done", done_cnt - d0, 0);
        check_eq("to_no_beats", beats - b0, 0);
        check_eq("to_err_sticky", err_timeout, 1);
        mode = 0;
        send_cmd(1, 1);
        check_eq("to_err_cleared", err_timeout, 0);
        wait_done("to_recover_done", 200);
        repeat (2) step();

        // Zero length
        b0 = beats; d0 = done_cnt; a0 = acc_cnt;
        send_cmd(0, 1);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        check_eq("zero_start", gen_ap_start, 0);
        repeat (4) step();
        check_eq("zero_dones", done_cnt - d0, 1);
        check_eq("zero_acc", acc_cnt - a0, 0);
        check_eq("zero_beats", beats - b0, 0);
        check_eq("zero_tvalid", m_axis_tvalid, 0);

        // Reset while beat 2 is stalled
        d0 = done_cnt; b0 = beats;
        mode = 0;
        send_cmd(1, 1);
        n = 0;
        while (beats - b0 < 2 && n < 200) begin
            step();
            n++;
        end
        m_axis_tready = 0;
        check_eq("rst_two_beats", beats - b0, 2);
        repeat (3) step();
        check_eq("rst_stall_tvalid", m_axis_tvalid, 1);
        check_eq("rst_stall_tdata", m_axis_tdata, 32'h33);
        rst_n = 0;
        #1;
        check_idle_outputs("rst_async");
        sb_q.delete();
        step();
        rst_n = 1;
        m_axis_tready = 1;
        repeat (3) step();
        check_eq("rst_no_done", done_cnt - d0, 0);
        run_basic("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
